da_sched: RTL and testbench

//   Bit-serial sequencer for the distributed-arithmetic FIR datapath.

---
 rtl/da_sched.sv | 150 +++++++++++++++
 tb/tb_da_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/da_sched.sv
`default_nettype none
// ==========================================================================
// da_sched -- bit-serial sequencer for the distributed-arithmetic FIR datapath
// Revision: 1.0
// ==========================================================================
module da_sched #(
  parameter int NBITS = 16,
  parameter int BW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          valid_in,
  input  logic          cload,
  output logic          load_sreg,
  output logic          shift_sreg,
  output logic          load_zreg,
  output logic          do_w0,
  output logic          do_w1,
  output logic          do_w2,
  output logic          do_w3,
  output logic          do_y0,
  output logic          do_y1,
  output logic          do_f0,
  output logic          do_acc,
  output logic          acc_clr,
  output logic          acc_sub,
  output logic [BW-1:0] bit_idx,
  output logic          busy,
  output logic          done,
  output logic          CEN,
  output logic          WEN
);

  typedef enum logic [14:0] {
    S_IDLE  = 15'h0001,
    S_LOAD  = 15'h0002,
    S_SREG  = 15'h0004,
    S_READ  = 15'h0008,
    S_ZREG  = 15'h0010,
    S_W0    = 15'h0020,
    S_W1    = 15'h0040,
    S_W2    = 15'h0080,
    S_W3    = 15'h0100,
    S_Y0    = 15'h0200,
    S_Y1    = 15'h0400,
    S_F0    = 15'h0800,
    S_ACC   = 15'h1000,
    S_SHIFT = 15'h2000,
    S_DONE  = 15'h4000
  } state_t;

  // Bit positions of the one-hot states that drive a strobe directly
  localparam int c_b_sreg  = 2;
  localparam int c_b_zreg  = 4;
  localparam int c_b_w0    = 5;
  localparam int c_b_w1    = 6;
  localparam int c_b_w2    = 7;
  localparam int c_b_w3    = 8;
  localparam int c_b_y0    = 9;
  localparam int c_b_y1    = 10;
  localparam int c_b_f0    = 11;
  localparam int c_b_acc   = 12;
  localparam int c_b_shift = 13;
  localparam int c_b_done  = 14;

  localparam logic [BW-1:0] c_last = BW'(NBITS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_bit_idx;
  logic          r_acc_clr;
  logic          r_acc_sub;
  logic          r_busy;
  logic          r_cen;
  logic          r_wen;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cload)                  w_next = S_LOAD;
        else if (start && valid_in) w_next = S_SREG;
      end
      S_LOAD:  if (!cload) w_next = S_IDLE;
      S_SREG:  w_next = S_READ;
      S_READ:  w_next = S_ZREG;
      S_ZREG:  w_next = S_W0;
      S_W0:    w_next = S_W1;
      S_W1:    w_next = S_W2;
      S_W2:    w_next = S_W3;
      S_W3:    w_next = S_Y0;
      S_Y0:    w_next = S_Y1;
      S_Y1:    w_next = S_F0;
      S_F0:    w_next = S_ACC;
      S_ACC:   w_next = (r_bit_idx == c_last) ? S_DONE : S_SHIFT;
      S_SHIFT: w_next = S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every non-strobe output is computed from the next state so it lands in a flop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_bit_idx <= '0;
      r_acc_clr <= 1'b0;
      r_acc_sub <= 1'b0;
      r_busy    <= 1'b0;
      r_cen     <= 1'b1;
      r_wen     <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == S_SREG)
        r_bit_idx <= '0;
      else if (r_state == S_SHIFT)
        r_bit_idx <= r_bit_idx + 1'b1;
      if (w_next == S_SREG)
        r_acc_clr <= 1'b1;
      else if (r_state == S_ACC)
        r_acc_clr <= 1'b0;
      r_acc_sub <= (w_next == S_ACC) && (r_bit_idx == c_last);
      r_busy    <= !((w_next == S_IDLE) || (w_next == S_DONE));
      r_cen     <= !((w_next == S_READ) || (w_next == S_LOAD));
      r_wen     <= !(w_next == S_LOAD);
    end
  end

  assign load_sreg  = r_state[c_b_sreg];
  assign shift_sreg = r_state[c_b_shift];
  assign load_zreg  = r_state[c_b_zreg];
  assign do_w0      = r_state[c_b_w0];
  assign do_w1      = r_state[c_b_w1];
  assign do_w2      = r_state[c_b_w2];
  assign do_w3      = r_state[c_b_w3];
  assign do_y0      = r_state[c_b_y0];
  assign do_y1      = r_state[c_b_y1];
  assign do_f0      = r_state[c_b_f0];
  assign do_acc     = r_state[c_b_acc];
  assign done       = r_state[c_b_done];
  assign acc_clr    = r_acc_clr;
  assign acc_sub    = r_acc_sub;
  assign bit_idx    = r_bit_idx;
  assign busy       = r_busy;
  assign CEN        = r_cen;
  assign WEN        = r_wen;

endmodule
`default_nettype wire

// File: tb/tb_da_sched.sv
`default_nettype none
// ==========================================================================
// tb_da_sched -- directed bench with a cycle-offset model of the sequencer
// Revision: 1.0
// ==========================================================================
module tb_da_sched;
  localparam int NB = 16;
  localparam int SL = 11;
  localparam int MI = 0, ML = 1, MR = 2, MD = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, valid_in = 1'b0, cload = 1'b0;
  logic       load_sreg, shift_sreg, load_zreg;
  logic       do_w0, do_w1, do_w2, do_w3, do_y0, do_y1, do_f0, do_acc;
  logic       acc_clr, acc_sub, busy, done, CEN, WEN;
  logic [3:0] bit_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_mode = MI;
  int m_t = 0;

  da_sched #(.NBITS(NB), .BW(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .valid_in(valid_in), .cload(cload),
    .load_sreg(load_sreg), .shift_sreg(shift_sreg), .load_zreg(load_zreg),
    .do_w0(do_w0), .do_w1(do_w1), .do_w2(do_w2), .do_w3(do_w3),
    .do_y0(do_y0), .do_y1(do_y1), .do_f0(do_f0), .do_acc(do_acc),
    .acc_clr(acc_clr), .acc_sub(acc_sub), .bit_idx(bit_idx),
    .busy(busy), .done(done), .CEN(CEN), .WEN(WEN)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: mode plus cycles elapsed since the accepting edge (t=0 is SREG)
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode <= MI;
      m_t    <= 0;
    end else begin
      case (m_mode)
        MI: begin
          if (cload) m_mode <= ML;
          else if (start && valid_in) begin m_mode <= MR; m_t <= 0; end
        end
        ML: if (!cload) m_mode <= MI;
        MR: if (m_t == SL*NB - 1) m_mode <= MD; else m_t <= m_t + 1;
        default: m_mode <= MI;
      endcase
    end
  end

  // {load_sreg,shift,zreg,w0,w1,w2,w3,y0,y1,f0,acc,acc_clr,acc_sub,busy,done,CEN,WEN}
  function automatic logic [16:0] exp_out(input int mode, input int t);
    logic [16:0] v;
    int p, s;
    v = 17'b11;
    case (mode)
      ML: begin v[3] = 1'b1; v[1] = 1'b0; v[0] = 1'b0; end
      MD: v[2] = 1'b1;
      MR: begin
        v[3] = 1'b1;
        v[5] = (t < SL);
        if (t == 0) v[16] = 1'b1;
        else begin
          p = (t - 1) % SL;
          s = (t - 1) / SL;
          case (p)
            0: v[1]  = 1'b0;
            1: v[14] = 1'b1;
            2: v[13] = 1'b1;
            3: v[12] = 1'b1;
            4: v[11] = 1'b1;
            5: v[10] = 1'b1;
            6: v[9]  = 1'b1;
            7: v[8]  = 1'b1;
            8: v[7]  = 1'b1;
            9: begin v[6] = 1'b1; v[4] = (s == NB - 1); end
            default: v[15] = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [16:0] got_out();
    return {load_sreg, shift_sreg, load_zreg, do_w0, do_w1, do_w2, do_w3, do_y0,
            do_y1, do_f0, do_acc, acc_clr, acc_sub, busy, done, CEN, WEN};
  endfunction

  always @(negedge clk) begin
    chk("outputs", 32'(got_out()), 32'(exp_out(m_mode, m_t)));
    if (m_mode == MR && m_t >= 1)
      chk("bit_idx", 32'(bit_idx), 32'((m_t - 1) / SL));
  end

  task automatic run_full(input string tag);
    int  e, lat, nz, na, ns, nc, nsub, sidx;
    bit  seen;
    @(negedge clk); start = 1'b1; valid_in = 1'b1;
    @(negedge clk); start = 1'b0;
    e = cyc;
    chk({tag, "_load_sreg_at_accept"}, 32'(load_sreg), 32'd1);
    nz = 0; na = 0; ns = 0; nsub = 0; sidx = 0; lat = 0; seen = 1'b0;
    nc = acc_clr ? 1 : 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (load_zreg)  nz++;
      if (do_acc)     na++;
      if (shift_sreg) ns++;
      if (acc_clr)    nc++;
      if (acc_sub) begin nsub++; sidx = int'(bit_idx); end
      if (done) begin seen = 1'b1; lat = cyc - e; end
    end
    chk({tag, "_done_latency"}, 32'(lat), 32'd176);
    chk({tag, "_zreg_pulses"},  32'(nz), 32'd16);
    chk({tag, "_acc_pulses"},   32'(na), 32'd16);
    chk({tag, "_shift_pulses"}, 32'(ns), 32'd15);
    chk({tag, "_acc_clr_cycles"}, 32'(nc), 32'd11);
    chk({tag, "_acc_sub_pulses"}, 32'(nsub), 32'd1);
    chk({tag, "_acc_sub_idx"},  32'(sidx), 32'd15);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int  nl, nsr, nd;
    int  tdone [3];
    bit  seen;

    // Reset
    @(negedge clk);
    chk("reset_outputs", 32'(got_out()), 32'h3);
    chk("reset_bit_idx", 32'(bit_idx), 32'd0);
    @(negedge clk); resetn = 1'b1;

    // 1 / 4: full run
    run_full("run1");

    // 2: start without valid_in stays idle
    @(negedge clk); start = 1'b1; valid_in = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("novalid_busy", 32'(busy), 32'd0);
    end
    valid_in = 1'b1;
    @(negedge clk);
    chk("valid_then_sreg", 32'(load_sreg), 32'd1);
    start = 1'b0;
    wait_done("run2");

    // 3: coefficient load wins over start
    @(negedge clk); cload = 1'b1; start = 1'b1; valid_in = 1'b1;
    nl = 0; nsr = 0;
    repeat (5) begin
      @(negedge clk);
      if (!CEN && !WEN) nl++;
      if (load_sreg) nsr++;
    end
    cload = 1'b0; start = 1'b0;
    chk("load_cycles", 32'(nl), 32'd5);
    chk("load_no_sreg", 32'(nsr), 32'd0);
    @(negedge clk);
    chk("load_exit_busy", 32'(busy), 32'd0);
    chk("load_exit_cen", 32'(CEN), 32'd1);

    // 5: async reset mid-W2 of slice 7
    @(negedge clk); start = 1'b1; valid_in = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (do_w2 && bit_idx == 4'd7) seen = 1'b1;
    end
    chk("found_w2_slice7", 32'(seen), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_outputs", 32'(got_out()), 32'h3);
    chk("async_rst_bit_idx", 32'(bit_idx), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'd0);
    run_full("rerun");

    // 6: continuous start, back-to-back results
    @(negedge clk); start = 1'b1; valid_in = 1'b1;
    nd = 0;
    for (int i = 0; i < 700 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin tdone[nd] = cyc; nd++; end
    end
    chk("b2b_done_count", 32'(nd), 32'd3);
    chk("b2b_period1", 32'(tdone[1] - tdone[0]), 32'd178);
    chk("b2b_period2", 32'(tdone[2] - tdone[1]), 32'd178);
    start = 1'b0;
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
